// File: rtl/plab5_mcore_debug_responder.sv
// plab5_mcore_debug_responder
// Executes debug copy/extract commands against main memory over a val/rdy
// request/response port, applying a domain-0 secure-region access policy.
module plab5_mcore_debug_responder #(
    parameter int unsigned                  p_addr_nbits = 32,
    parameter int unsigned                  p_data_nbits = 32,
    parameter logic [p_addr_nbits-1:0]      p_sec_base   = 32'h8000_0000
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    start,
    input  logic                    inst,
    input  logic [p_addr_nbits-1:0] src_addr,
    input  logic [p_addr_nbits-1:0] dest_addr,
    input  logic                    domain,

    output logic                    ack,
    output logic                    resp_domain,
    output logic [p_data_nbits-1:0] read_data,
    output logic                    db_resp_domain,
    output logic                    denied,

    output logic                    memreq_val,
    input  logic                    memreq_rdy,
    output logic                    memreq_type,
    output logic [p_addr_nbits-1:0] memreq_addr,
    output logic [p_data_nbits-1:0] memreq_data,

    input  logic                    memresp_val,
    output logic                    memresp_rdy,
    input  logic [p_data_nbits-1:0] memresp_data
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        ACK
    } state_t;

    state_t                  state;

    logic                    cmd_inst;
    logic                    cmd_domain;
    logic [p_addr_nbits-1:0] cmd_src;
    logic [p_addr_nbits-1:0] cmd_dest;
    logic [p_data_nbits-1:0] data_reg;
    logic                    deny;

    logic                    src_secure;
    logic                    dest_secure;
    logic                    violation;

    // Policy: domain 0 may not touch the secure region (dest only matters for copy)
    always_comb begin
        src_secure  = (cmd_src  >= p_sec_base);
        dest_secure = (cmd_dest >= p_sec_base);
        violation   = !cmd_domain && (src_secure || (!cmd_inst && dest_secure));
    end

    // Write data always comes from the captured read word; domain tags follow the latched command
    assign memreq_data    = data_reg;
    assign resp_domain    = cmd_domain;
    assign db_resp_domain = cmd_domain;
    assign denied         = deny;

    // Command FSM; memory-port and ack outputs are registered and set on entry to each state
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cmd_inst    <= 1'b0;
            cmd_domain  <= 1'b0;
            cmd_src     <= '0;
            cmd_dest    <= '0;
            data_reg    <= '0;
            deny        <= 1'b0;
            ack         <= 1'b0;
            read_data   <= '0;
            memreq_val  <= 1'b0;
            memreq_type <= 1'b0;
            memreq_addr <= '0;
            memresp_rdy <= 1'b0;
        end else begin
            ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cmd_inst   <= inst;
                        cmd_src    <= src_addr;
                        cmd_dest   <= dest_addr;
                        cmd_domain <= domain;
                        state      <= CHECK;
                    end
                end
                CHECK: begin
                    if (violation) begin
                        deny  <= 1'b1;
                        ack   <= 1'b1;
                        if (cmd_inst) begin
                            read_data <= '0;
                        end
                        state <= ACK;
                    end else begin
                        deny        <= 1'b0;
                        memreq_val  <= 1'b1;
                        memreq_type <= 1'b0;
                        memreq_addr <= cmd_src;
                        state       <= RD_REQ;
                    end
                end
                RD_REQ: begin
                    if (memreq_rdy) begin
                        memreq_val  <= 1'b0;
                        memresp_rdy <= 1'b1;
                        state       <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (memresp_val) begin
                        data_reg    <= memresp_data;
                        memresp_rdy <= 1'b0;
                        if (cmd_inst) begin
                            // read_data lands together with ack so it is valid in the ack cycle
                            read_data <= memresp_data;
                            ack       <= 1'b1;
                            state     <= ACK;
                        end else begin
                            memreq_val  <= 1'b1;
                            memreq_type <= 1'b1;
                            memreq_addr <= cmd_dest;
                            state       <= WR_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    if (memreq_rdy) begin
                        memreq_val  <= 1'b0;
                        memresp_rdy <= 1'b1;
                        state       <= WR_WAIT;
                    end
                end
                WR_WAIT: begin
                    if (memresp_val) begin
                        memresp_rdy <= 1'b0;
                        ack         <= 1'b1;
                        state       <= ACK;
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_plab5_mcore_debug_responder.sv
// Testbench for plab5_mcore_debug_responder: directed plan items plus
// randomized commands against an abstract per-command reference model.
module tb_plab5_mcore_debug_responder;

    localparam logic [31:0] SEC = 32'h8000_0000;

    logic        clk;
    logic        reset;
    logic        start;
    logic        inst;
    logic [31:0] src_addr;
    logic [31:0] dest_addr;
    logic        domain;
    logic        ack;
    logic        resp_domain;
    logic [31:0] read_data;
    logic        db_resp_domain;
    logic        denied;
    logic        memreq_val;
    logic        memreq_rdy;
    logic        memreq_type;
    logic [31:0] memreq_addr;
    logic [31:0] memreq_data;
    logic        memresp_val;
    logic        memresp_rdy;
    logic [31:0] memresp_data;

    plab5_mcore_debug_responder #(
        .p_addr_nbits (32),
        .p_data_nbits (32),
        .p_sec_base   (32'h8000_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .inst           (inst),
        .src_addr       (src_addr),
        .dest_addr      (dest_addr),
        .domain         (domain),
        .ack            (ack),
        .resp_domain    (resp_domain),
        .read_data      (read_data),
        .db_resp_domain (db_resp_domain),
        .denied         (denied),
        .memreq_val     (memreq_val),
        .memreq_rdy     (memreq_rdy),
        .memreq_type    (memreq_type),
        .memreq_addr    (memreq_addr),
        .memreq_data    (memreq_data),
        .memresp_val    (memresp_val),
        .memresp_rdy    (memresp_rdy),
        .memresp_data   (memresp_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        typ;
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    int          checks = 0;
    int          errors = 0;

    logic [31:0] mem     [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    req_t        log_q[$];
    req_t        exp_q[$];
    logic [31:0] rd_model = '0;

    // memory responder state, plans are loaded by the command driver
    int          plan_req  [3];
    int          plan_resp [3];
    int          nreq      = 0;
    int          cnt_stall = 0;
    int          cnt_wait  = 0;
    bit          pending   = 0;
    bit          prev_stall = 0;
    logic        h_typ;
    logic [31:0] h_addr;
    logic [31:0] h_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_A5A5;
    endfunction

    function automatic logic [31:0] mem_get(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return dflt(a);
    endfunction

    function automatic logic [31:0] ref_get(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return dflt(a);
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        mem[a]     = v;
        ref_mem[a] = v;
    endtask

    // Memory model: samples the port at negedge, acts just after the posedge
    initial begin
        logic        s_rst, s_req_fire, s_req_stall, s_resp_fire, s_resp_wait;
        logic        s_typ;
        logic [31:0] s_addr, s_data;
        req_t        r;
        int          ri, pi;
        for (int i = 0; i < 3; i++) begin
            plan_req[i]  = 0;
            plan_resp[i] = 0;
        end
        memreq_rdy   = 1'b1;
        memresp_val  = 1'b0;
        memresp_data = '0;
        forever begin
            @(negedge clk);
            s_rst = reset;
            if (!s_rst && prev_stall) begin
                check("req_hold_val",  32'(memreq_val), 32'd1);
                check("req_hold_type", 32'(memreq_type), 32'(h_typ));
                check("req_hold_addr", memreq_addr, h_addr);
                check("req_hold_data", memreq_data, h_data);
            end
            s_req_fire  = memreq_val && memreq_rdy;
            s_req_stall = memreq_val && !memreq_rdy;
            s_resp_fire = memresp_rdy && memresp_val;
            s_resp_wait = memresp_rdy && !memresp_val && pending;
            s_typ  = memreq_type;
            s_addr = memreq_addr;
            s_data = memreq_data;
            prev_stall = s_req_stall && !s_rst;
            h_typ  = s_typ;
            h_addr = s_addr;
            h_data = s_data;
            @(posedge clk);
            #1;
            if (s_rst) begin
                pending   = 0;
                cnt_stall = 0;
                cnt_wait  = 0;
            end else begin
                if (s_resp_fire) pending = 0;
                if (s_resp_wait) cnt_wait++;
                if (s_req_stall) cnt_stall++;
                if (s_req_fire) begin
                    r.typ  = s_typ;
                    r.addr = s_addr;
                    r.data = s_data;
                    log_q.push_back(r);
                    if (s_typ) begin
                        mem[s_addr]  = s_data;
                        memresp_data = $urandom;
                    end else begin
                        memresp_data = mem_get(s_addr);
                    end
                    pending   = 1;
                    cnt_wait  = 0;
                    cnt_stall = 0;
                    nreq++;
                end
            end
            ri = (nreq > 2) ? 2 : nreq;
            pi = (nreq == 0) ? 0 : ((nreq > 3) ? 2 : nreq - 1);
            memreq_rdy  = (cnt_stall >= plan_req[ri]);
            memresp_val = pending && (cnt_wait >= plan_resp[pi]);
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"},         32'(ack), 32'd0);
        check({tag, "_denied"},      32'(denied), 32'd0);
        check({tag, "_memreq_val"},  32'(memreq_val), 32'd0);
        check({tag, "_memresp_rdy"}, 32'(memresp_rdy), 32'd0);
        check({tag, "_read_data"},   read_data, 32'd0);
        check({tag, "_resp_dom"},    32'(resp_domain), 32'd0);
        check({tag, "_db_dom"},      32'(db_resp_domain), 32'd0);
    endtask

    // Issue one command (called at posedge+2) and check it against the model.
    // pulse_at: 0 none, -1 random cycle while busy, >0 exact cycle offset.
    task automatic run_cmd(input logic inst_i, input logic [31:0] src_i, input logic [31:0] dest_i,
                           input logic dom_i, input int s0, input int d0, input int s1,
                           input int d1, input int pulse_at);
        logic        dn;
        logic [31:0] v;
        int          exp_lat, k, pa;
        bit          got;
        req_t        e;
        dn = !dom_i && ((src_i >= SEC) || (!inst_i && (dest_i >= SEC)));
        v  = ref_get(src_i);
        exp_q.delete();
        if (!dn) begin
            e.typ = 1'b0; e.addr = src_i; e.data = '0;
            exp_q.push_back(e);
            if (!inst_i) begin
                e.typ = 1'b1; e.addr = dest_i; e.data = v;
                exp_q.push_back(e);
            end
        end
        exp_lat = dn ? 2 : (inst_i ? 4 + s0 + d0 : 6 + s0 + d0 + s1 + d1);
        if (inst_i) rd_model = dn ? 32'd0 : v;
        if (!dn && !inst_i) ref_mem[dest_i] = v;
        pa = (pulse_at < 0) ? int'($urandom_range(1, exp_lat)) : pulse_at;

        plan_req[0] = s0; plan_resp[0] = d0;
        plan_req[1] = s1; plan_resp[1] = d1;
        plan_req[2] = 0;  plan_resp[2] = 0;
        nreq = 0; cnt_stall = 0; cnt_wait = 0;
        log_q.delete();

        start = 1'b1; inst = inst_i; src_addr = src_i; dest_addr = dest_i; domain = dom_i;
        k = 0; got = 0;
        while (!got && k <= 60) begin
            @(negedge clk);
            if (ack) got = 1;
            else begin
                @(posedge clk); #2;
                k++;
                start = (pa == k);
            end
        end
        check("ack_seen",    32'(got), 32'd1);
        check("ack_latency", 32'(k), 32'(exp_lat));
        check("denied",      32'(denied), 32'(dn));
        check("resp_domain", 32'(resp_domain), 32'(dom_i));
        check("db_domain",   32'(db_resp_domain), 32'(dom_i));
        check("read_data",   read_data, rd_model);
        @(posedge clk); #2;
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("ack_single", 32'(ack), 32'd0);
            check("idle_req",   32'(memreq_val), 32'd0);
            @(posedge clk); #2;
        end
        check("read_data_hold", read_data, rd_model);
        check("req_count", 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            check("req_type", 32'(log_q[i].typ), 32'(exp_q[i].typ));
            check("req_addr", log_q[i].addr, exp_q[i].addr);
            if (exp_q[i].typ) check("req_wdata", log_q[i].data, exp_q[i].data);
        end
        if (!dn && !inst_i) check("mem_dest", mem_get(dest_i), ref_get(dest_i));
    endtask

    task automatic run_reset_mid_copy();
        logic [31:0] s, d, v;
        s = 32'h104;
        d = 32'h204;
        v = ref_get(s);
        ref_mem[d] = v;          // the write is accepted before reset hits
        plan_req[0] = 0; plan_resp[0] = 0;
        plan_req[1] = 0; plan_resp[1] = 5;
        plan_req[2] = 0; plan_resp[2] = 0;
        nreq = 0; cnt_stall = 0; cnt_wait = 0;
        log_q.delete();
        start = 1'b1; inst = 1'b0; src_addr = s; dest_addr = d; domain = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rst_no_ack", 32'(ack), 32'd0);
            @(posedge clk); #2;
            start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        check("rst_in_wr_wait", 32'(memresp_rdy), 32'd1);
        @(posedge clk); #2;
        reset = 1'b0;
        rd_model = '0;
        @(negedge clk);
        check_reset_outputs("midrst");
        repeat (4) begin
            @(posedge clk); #2;
            @(negedge clk);
            check("midrst_no_ack", 32'(ack), 32'd0);
        end
        @(posedge clk); #2;
        run_cmd(1'b1, d, 32'h0, 1'b1, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 4))
            0, 1:    return 32'h100 + 32'(4 * $urandom_range(0, 63));
            2:       return SEC + 32'(4 * $urandom_range(0, 63));
            3:       return 32'h7FFF_FFFC;
            default: return SEC;
        endcase
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; inst = 1'b0;
        src_addr = '0; dest_addr = '0; domain = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #2;
        reset = 1'b0;
        @(posedge clk); #2;

        preload(32'h8000_0010, 32'hDEAD_BEEF);
        preload(32'h0000_0100, 32'h1234_5678);
        run_cmd(1'b1, 32'h8000_0010, 32'h0,         1'b1, 0, 0, 0, 0, 0);
        run_cmd(1'b0, 32'h0000_0100, 32'h200,       1'b0, 0, 0, 0, 0, 0);
        run_cmd(1'b1, 32'h8000_0000, 32'h0,         1'b0, 0, 0, 0, 0, 0);
        run_cmd(1'b0, 32'h0000_0100, 32'h8000_0004, 1'b0, 0, 0, 0, 0, 0);
        run_cmd(1'b1, 32'h0000_0140, 32'h0,         1'b1, 3, 2, 0, 0, 0);
        run_cmd(1'b1, 32'h0000_0180, 32'h0,         1'b0, 0, 0, 0, 0, 3);
        run_cmd(1'b0, 32'h0000_0104, 32'h7FFF_FFFC, 1'b0, 1, 2, 2, 1, 0);

        for (int unsigned n = 0; n < 40; n++) begin
            run_cmd(1'($urandom_range(0, 1)), rand_addr(), rand_addr(), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                    ($urandom_range(0, 1) == 1) ? -1 : 0);
        end

        run_reset_mid_copy();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/plab5_mcore_debug_responder.md
# plab5_mcore_debug_responder

Memory-side responder for the multicore debug path. It accepts single-cycle `start` commands from the debug interface and executes each one against main memory over a val/rdy request/response port. A copy command moves one word from `src_addr` to `dest_addr`; an extract command reads `src_addr` and returns the word. Every command is acknowledged with a one-cycle `ack` tagged with the command's security domain, and domain-0 access to the secure region is refused.

## Interface
- `p_addr_nbits`, 32, address width
- `p_data_nbits`, 32, data width
- `p_sec_base`, 32'h8000_0000, lowest secure address; `addr >= p_sec_base` is secure

Ports:
- `clk` in 1: the single clock
- `reset` in 1: synchronous, active-high
- `start` in 1: command strobe, sampled only in IDLE
- `inst` in 1: 0 = copy, 1 = extract
- `src_addr` in `p_addr_nbits`: source/read address
- `dest_addr` in `p_addr_nbits`: copy destination, ignored for extract
- `domain` in 1: requester security domain, 1 = secure
- `ack` out 1: one-cycle completion pulse
- `resp_domain` out 1: domain tag for `ack`
- `read_data` out `p_data_nbits`: extract result
- `db_resp_domain` out 1: domain tag for `read_data`
- `denied` out 1: valid with `ack`; 1 = command refused
- `memreq_val` out 1, `memreq_rdy` in 1
- `memreq_type` out 1: 0 = read, 1 = write
- `memreq_addr` out `p_addr_nbits`, `memreq_data` out `p_data_nbits`
- `memresp_val` in 1, `memresp_rdy` out 1
- `memresp_data` in `p_data_nbits`

## Operation
- States: IDLE, CHECK, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, ACK.
- **IDLE**
  - On `start`=1, latch `inst`, `src_addr`, `dest_addr`, `domain` into command registers, then go to CHECK.
  - `start` in any other state is ignored and never queued.
- **CHECK (policy)**
  - Deny when latched domain=0 and `src_addr >= p_sec_base`.
  - For copy, also deny when latched domain=0 and `dest_addr >= p_sec_base`.
  - Deny: set the deny flag and go to ACK. No memory request is issued.
  - Otherwise clear the deny flag and go to RD_REQ.
- **RD_REQ**
  - Drive `memreq_val`=1, type=0, addr=src.
  - On `memreq_rdy`, go to RD_WAIT.
- **RD_WAIT**
  - `memresp_rdy`=1.
  - On `memresp_val`, capture `memresp_data` into the data register.
  - Next state: WR_REQ if copy, ACK if extract.
- **WR_REQ**
  - Drive `memreq_val`=1, type=1, addr=dest, data=data register.
  - On `memreq_rdy`, go to WR_WAIT.
- **WR_WAIT**
  - `memresp_rdy`=1.
  - On `memresp_val`, go to ACK; the response data is discarded.
- **ACK**
  - `ack`=1 for exactly one cycle.
  - `denied` reflects the deny flag.
  - `resp_domain` and `db_resp_domain` equal the latched domain.
  - Next state: IDLE.
- **`read_data`**
  - Updated only on completion of an extract command.
  - Allowed extract: takes the captured word. Denied extract: forced to 0.
  - Held until the next extract completes; copy commands never change it.
- **Domain outputs:** `resp_domain` and `db_resp_domain` hold the latched domain at all times after the first command.
- **Handshake guarantee:** `memreq_*` fields are stable while `memreq_val`=1 and `memreq_rdy`=0.
- **Memory-port idle values:** `memreq_val`=0 and `memresp_rdy`=0 in IDLE, CHECK and ACK; a `memresp_val` arriving then is not consumed.

## Timing
- **Reset values:** state IDLE; `ack`, `denied`, `memreq_val`, `memresp_rdy` = 0; `read_data` = 0; `resp_domain` = `db_resp_domain` = 0; command and data registers = 0.
- **Reset mid-command:** any in-flight command is abandoned, with no `ack`.
- **Latency**, with `memreq_rdy` always 1 and a one-cycle memory response, `start` high in cycle t:
  - CHECK in t+1.
  - `memreq_val` (read) in t+2.
  - Read response in t+3.
  - Extract: `ack` in t+4.
  - Copy: write request t+4, write response t+5, `ack` t+6.
  - Denied command: `ack` in t+2.
- Each cycle `memreq_rdy`=0 or `memresp_val`=0 adds exactly one cycle.
- `ack` and `read_data` update in the same cycle; `read_data` is valid in the `ack` cycle.
- The earliest next command is `start` in the cycle after `ack`.
- `start` may be held high: re-sampling occurs in the next IDLE, so a held `start` issues a new command.

## Test plan
- **Extract, domain 1:** mem[0x8000_0010]=0xDEAD_BEEF, start inst=1 src=0x8000_0010 at t → one read at t+2, `ack` at t+4, `read_data`=0xDEAD_BEEF, `denied`=0, `db_resp_domain`=1.
- **Copy, domain 0:** mem[0x100]=0x1234_5678, src=0x100 dest=0x200 → read 0x100, then write 0x200 with data 0x1234_5678, `ack` at t+6, mem[0x200]=0x1234_5678, `read_data` unchanged.
- **Denied requests, domain 0:**
  - Extract with src=0x8000_0000 → no `memreq_val` ever, `ack` at t+2, `denied`=1, `read_data`=0.
  - Copy with src=0x100 dest=0x8000_0004 → `denied`=1, no memory traffic.
- **Backpressure:** `memreq_rdy` low for 3 cycles, then response delayed 2 cycles on an extract → `memreq` fields stable while stalled, `ack` at t+9, exactly one request issued.
- **Protocol edges:**
  - Pulse `start` during RD_WAIT → ignored, only one `ack`.
  - Assert `reset` during WR_WAIT → no `ack`, all outputs return to reset values next cycle, and a fresh command afterward completes normally.
